sssp_child_stage: RTL and testbench
===================================

SSSP_CHILD_STAGE -- requirements
Module: sssp_child_stage

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, child-entry buffer depth (power of 2, >=2); CQ_SLOT_W, default 4, commit-queue slot width; COUNT_W, default 8, per-parent child-count width.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset; asynchronous assertion, active-low.
REQ-004 in_valid  input  1  upstream beat valid (read-only stage output).
REQ-005 in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-006 in_ts  input  32  parent task timestamp.
REQ-007 in_cq_slot  input  CQ_SLOT_W  parent commit-queue slot.
REQ-008 in_data  input  64  neighbour record: [63:32] edge weight, [31:0] neighbour locale.
REQ-009 in_last  input  1  final beat of this parent.
REQ-010 child_valid  output  1  child entry available.
REQ-011 child_ready  input  1  child entry popped when child_valid & child_ready.
REQ-012 child_ts  output  32  child timestamp.
REQ-013 child_locale  output  32  child locale.
REQ-014 child_cq_slot  output  CQ_SLOT_W  parent slot of this child.
REQ-015 finish_valid  output  1  parent-complete record valid.
REQ-016 finish_ready  input  1  record consumed when finish_valid & finish_ready.
REQ-017 finish_cq_slot  output  CQ_SLOT_W  completed parent slot.
REQ-018 finish_n_children  output  COUNT_W  children generated for that parent.
REQ-019 overflow  output  1  sticky: a parent exceeded 2^COUNT_W-1 children.
REQ-020 idle  output  1  no buffered children, no pending finish, no open parent.

Function
REQ-021 in_ready SHALL equal (FIFO not full) AND (no finish pending); no same-cycle bypass when full, even if a pop occurs.
REQ-022 Each accepted beat SHALL push one entry: child_ts = in_ts + in_data[63:32] modulo 2^32, child_locale = in_data[31:0], child_cq_slot = in_cq_slot.
REQ-023 Pushed entry SHALL appear on child outputs no earlier than the cycle after acceptance; FIFO order preserved.
REQ-024 child_valid SHALL equal FIFO non-empty; child outputs SHALL reflect the head entry and hold stable while child_valid & !child_ready.
REQ-025 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 Open-parent counter SHALL increment per accepted non-last beat, saturating at 2^COUNT_W-1; saturation attempt SHALL set overflow.
REQ-027 On accepted last beat: finish_pending set, finish_cq_slot = in_cq_slot, finish_n_children = counter+1 (saturating, same overflow rule), counter cleared to 0.
REQ-028 finish_valid SHALL equal finish_pending AND FIFO empty, so a parent's finish never precedes its children's pops.
REQ-029 finish_pending SHALL clear on finish_valid & finish_ready; in_ready may reassert the following cycle.
REQ-030 Finish outputs SHALL hold stable while finish_valid & !finish_ready.
REQ-031 idle SHALL equal FIFO empty AND !finish_pending AND counter == 0.
REQ-032 Upstream in_cq_slot and in_ts SHALL be constant across a parent's beats; behaviour otherwise is not required.

Reset
REQ-033 While rstn low: FIFO empty, pointers 0, counter 0, finish_pending 0, overflow 0; hence in_ready=1, child_valid=0, finish_valid=0, idle=1.
REQ-034 Reset mid-operation SHALL discard buffered children and any pending finish without emitting them.
REQ-035 Data-only FIFO storage need not be reset.

Verification
REQ-036 Single beat ts=100, data={5,7}, last=1, slot=3, child_ready=1 -> one child ts=105 locale=7 slot=3, then finish slot=3 n=1, idle=1.
REQ-037 Three beats one parent, child_ready=0 -> FIFO holds 3, finish_valid=0; release child_ready -> 3 children in order, then finish n=3.
REQ-038 FIFO_DEPTH=4, child_ready=0, 5 non-last beats offered -> 4 accepted, in_ready=0 on fifth; one pop -> fifth accepted next cycle.
REQ-039 Timestamp wrap: ts=0xFFFFFFF0, weight=0x20 -> child_ts=0x00000010.
REQ-040 finish_ready=0 with finish pending -> in_ready=0, outputs stable; assert finish_ready -> finish consumed, next parent accepted.
REQ-041 rstn low with 2 children buffered and finish pending -> all valids 0 immediately, idle=1, no stale child after release.

Source files
------------

// File: rtl/sssp_child_stage_if.sv
// ============================================================================
// Module  : sssp_child_stage_if
// Brief   : Parent-beat input, child-entry output and finish-record channels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sssp_child_stage_if #(
  parameter int CQ_SLOT_W = 4,
  parameter int COUNT_W   = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_ts;
  logic [CQ_SLOT_W-1:0] in_cq_slot;
  logic [63:0]          in_data;
  logic                 in_last;

  logic                 child_valid;
  logic                 child_ready;
  logic [31:0]          child_ts;
  logic [31:0]          child_locale;
  logic [CQ_SLOT_W-1:0] child_cq_slot;

  logic                 finish_valid;
  logic                 finish_ready;
  logic [CQ_SLOT_W-1:0] finish_cq_slot;
  logic [COUNT_W-1:0]   finish_n_children;

  logic                 overflow;
  logic                 idle;

  modport master (
    output in_valid, in_ts, in_cq_slot, in_data, in_last, child_ready, finish_ready,
    input  in_ready, child_valid, child_ts, child_locale, child_cq_slot,
    input  finish_valid, finish_cq_slot, finish_n_children, overflow, idle
  );

  modport slave (
    input  in_valid, in_ts, in_cq_slot, in_data, in_last, child_ready, finish_ready,
    output in_ready, child_valid, child_ts, child_locale, child_cq_slot,
    output finish_valid, finish_cq_slot, finish_n_children, overflow, idle
  );
endinterface

`default_nettype wire

// File: rtl/sssp_child_stage.sv
// ============================================================================
// Module  : sssp_child_stage
// Brief   : Turns neighbour beats into child tasks and emits a per-parent
//           completion record once all of that parent's children have drained.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sssp_child_stage #(
  parameter int FIFO_DEPTH = 4,
  parameter int CQ_SLOT_W  = 4,
  parameter int COUNT_W    = 8
) (
  input  wire logic clk,
  input  wire logic rstn,
  sssp_child_stage_if.slave bus
);

  localparam int                 c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [COUNT_W-1:0] c_CNT_MAX = '1;

  logic [31:0]          r_mem_ts   [FIFO_DEPTH];
  logic [31:0]          r_mem_loc  [FIFO_DEPTH];
  logic [CQ_SLOT_W-1:0] r_mem_slot [FIFO_DEPTH];

  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_used;
  logic [COUNT_W-1:0]   r_par_cnt;
  logic                 r_fin_pend;
  logic [CQ_SLOT_W-1:0] r_fin_slot;
  logic [COUNT_W-1:0]   r_fin_n;
  logic                 r_ovf;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_in_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fin_valid;
  logic                 w_fin_take;
  logic                 w_cnt_sat;
  logic [COUNT_W-1:0]   w_cnt_next;

  assign w_full      = (r_used == c_DEPTH);
  assign w_empty     = (r_used == '0);
  // A pending finish blocks new beats so the next parent cannot reuse the counter early.
  assign w_in_ready  = !w_full && !r_fin_pend;
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = !w_empty && bus.child_ready;
  assign w_fin_valid = r_fin_pend && w_empty;
  assign w_fin_take  = w_fin_valid && bus.finish_ready;
  assign w_cnt_sat   = (r_par_cnt == c_CNT_MAX);
  assign w_cnt_next  = w_cnt_sat ? c_CNT_MAX : r_par_cnt + COUNT_W'(1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ts[r_wr_ptr]   <= bus.in_ts + bus.in_data[63:32];
      r_mem_loc[r_wr_ptr]  <= bus.in_data[31:0];
      r_mem_slot[r_wr_ptr] <= bus.in_cq_slot;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_used     <= '0;
      r_par_cnt  <= '0;
      r_fin_pend <= 1'b0;
      r_fin_slot <= '0;
      r_fin_n    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_used <= r_used + (c_PTR_W + 1)'(1);
        2'b01:   r_used <= r_used - (c_PTR_W + 1)'(1);
        default: r_used <= r_used;
      endcase

      if (w_fin_take) r_fin_pend <= 1'b0;

      if (w_push) begin
        if (w_cnt_sat) r_ovf <= 1'b1;
        if (bus.in_last) begin
          r_fin_pend <= 1'b1;
          r_fin_slot <= bus.in_cq_slot;
          r_fin_n    <= w_cnt_next;
          r_par_cnt  <= '0;
        end else begin
          r_par_cnt  <= w_cnt_next;
        end
      end
    end
  end

  assign bus.in_ready          = w_in_ready;
  assign bus.child_valid       = !w_empty;
  assign bus.child_ts          = r_mem_ts[r_rd_ptr];
  assign bus.child_locale      = r_mem_loc[r_rd_ptr];
  assign bus.child_cq_slot     = r_mem_slot[r_rd_ptr];
  assign bus.finish_valid      = w_fin_valid;
  assign bus.finish_cq_slot    = r_fin_slot;
  assign bus.finish_n_children = r_fin_n;
  assign bus.overflow          = r_ovf;
  assign bus.idle              = w_empty && !r_fin_pend && (r_par_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_sssp_child_stage.sv
// ============================================================================
// Module  : tb_sssp_child_stage
// Brief   : Directed and randomized bench with a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sssp_child_stage;
  localparam int DEPTH   = 4;
  localparam int SLOT_W  = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  sssp_child_stage_if #(.CQ_SLOT_W(SLOT_W), .COUNT_W(CNT_W)) bus ();

  sssp_child_stage #(.FIFO_DEPTH(DEPTH), .CQ_SLOT_W(SLOT_W), .COUNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       ts;
    logic [31:0]       loc;
    logic [SLOT_W-1:0] slot;
  } ent_t;

  ent_t              q[$];
  bit                m_pend;
  logic [SLOT_W-1:0] m_fslot;
  int                m_fn;
  int                m_cnt;
  bit                m_ovf;
  bit                parent_done;
  int                n_checks;
  int                n_fail;

  function automatic bit m_in_ready();
    return (q.size() < DEPTH) && !m_pend;
  endfunction

  function automatic bit m_fin_valid();
    return m_pend && (q.size() == 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend  = 1'b0;
    m_fslot = '0;
    m_fn    = 0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
  endtask

  // Applies one clock edge worth of handshakes to the abstract model.
  task automatic model_step();
    bit   push, pop, take;
    ent_t e;
    if (!rstn) begin
      model_reset();
      return;
    end
    push = bus.in_valid && m_in_ready();
    pop  = (q.size() > 0) && bus.child_ready;
    take = m_fin_valid() && bus.finish_ready;
    if (pop)  e = q.pop_front();
    if (take) m_pend = 1'b0;
    if (push) begin
      e.ts   = bus.in_ts + bus.in_data[63:32];
      e.loc  = bus.in_data[31:0];
      e.slot = bus.in_cq_slot;
      q.push_back(e);
      if (bus.in_last) begin
        m_pend  = 1'b1;
        m_fslot = bus.in_cq_slot;
        if (m_cnt + 1 > CNT_MAX) begin
          m_fn  = CNT_MAX;
          m_ovf = 1'b1;
        end else begin
          m_fn = m_cnt + 1;
        end
        m_cnt       = 0;
        parent_done = 1'b1;
      end else if (m_cnt == CNT_MAX) begin
        m_ovf = 1'b1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ts, input logic [31:0] wt,
                       input logic [31:0] loc, input bit last, input logic [SLOT_W-1:0] slot,
                       input bit cr, input bit fr);
    bus.in_valid     = v;
    bus.in_ts        = ts;
    bus.in_data      = {wt, loc};
    bus.in_last      = last;
    bus.in_cq_slot   = slot;
    bus.child_ready  = cr;
    bus.finish_ready = fr;
  endtask

  always @(negedge clk) begin
    chk("in_ready", 64'(bus.in_ready), 64'(m_in_ready()));
    chk("child_valid", 64'(bus.child_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("child_ts", 64'(bus.child_ts), 64'(q[0].ts));
      chk("child_locale", 64'(bus.child_locale), 64'(q[0].loc));
      chk("child_cq_slot", 64'(bus.child_cq_slot), 64'(q[0].slot));
    end
    chk("finish_valid", 64'(bus.finish_valid), 64'(m_fin_valid()));
    if (m_fin_valid()) begin
      chk("finish_cq_slot", 64'(bus.finish_cq_slot), 64'(m_fslot));
      chk("finish_n", 64'(bus.finish_n_children), 64'(m_fn));
    end
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("idle", 64'(bus.idle), 64'((q.size() == 0) && !m_pend && (m_cnt == 0)));
  end

  initial begin
    logic [31:0]       p_ts;
    logic [SLOT_W-1:0] p_slot;
    bit                seen;
    n_checks    = 0;
    n_fail      = 0;
    parent_done = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_child_valid", 64'(bus.child_valid), 64'd0);
    chk("rst_finish_valid", 64'(bus.finish_valid), 64'd0);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    rstn = 1'b1;

    // Single-beat parent.
    drive(1, 100, 5, 7, 1, 3, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("t1_child_ts", 64'(bus.child_ts), 64'd105);
    chk("t1_child_loc", 64'(bus.child_locale), 64'd7);
    chk("t1_child_slot", 64'(bus.child_cq_slot), 64'd3);
    chk("t1_fin_early", 64'(bus.finish_valid), 64'd0);
    tick();
    chk("t1_fin_valid", 64'(bus.finish_valid), 64'd1);
    chk("t1_fin_slot", 64'(bus.finish_cq_slot), 64'd3);
    chk("t1_fin_n", 64'(bus.finish_n_children), 64'd1);
    tick();
    chk("t1_idle", 64'(bus.idle), 64'd1);

    // Three beats held in the FIFO, then released.
    drive(1, 200, 1, 10, 0, 5, 0, 1); tick();
    drive(1, 200, 2, 11, 0, 5, 0, 1); tick();
    drive(1, 200, 3, 12, 1, 5, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t2_fin_blocked", 64'(bus.finish_valid), 64'd0);
    chk("t2_head_ts", 64'(bus.child_ts), 64'd201);
    chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    tick(); tick(); tick();
    chk("t2_fin_valid", 64'(bus.finish_valid), 64'd1);
    chk("t2_fin_n", 64'(bus.finish_n_children), 64'd3);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    tick();

    // Full FIFO backpressure.
    for (int i = 0; i < 4; i++) begin
      drive(1, 300, 32'(i), 32'(i), 0, 6, 0, 0);
      tick();
    end
    chk("t3_full_ready", 64'(bus.in_ready), 64'd0);
    drive(1, 300, 4, 55, 0, 6, 0, 0); tick();
    chk("t3_still_full", 64'(bus.in_ready), 64'd0);
    drive(1, 300, 4, 55, 0, 6, 1, 0); tick();
    chk("t3_after_pop", 64'(bus.in_ready), 64'd1);
    drive(1, 300, 4, 55, 0, 6, 0, 0); tick();
    chk("t3_refull", 64'(bus.in_ready), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_open_parent", 64'(bus.idle), 64'd0);
    drive(1, 300, 9, 99, 1, 6, 1, 0); tick();
    drive(1, 32'hFFFF_FFF0, 32'h20, 9, 1, 7, 1, 0); tick();
    chk("t3_fin_n", 64'(bus.finish_n_children), 64'd6);

    // Finish backpressure, then wrapping timestamp for the next parent.
    tick(); tick();
    chk("t4_in_blocked", 64'(bus.in_ready), 64'd0);
    chk("t4_fin_hold", 64'(bus.finish_cq_slot), 64'd6);
    drive(1, 32'hFFFF_FFF0, 32'h20, 9, 1, 7, 0, 1); tick();
    chk("t4_ready_back", 64'(bus.in_ready), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_wrap_ts", 64'(bus.child_ts), 64'h10);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    tick(); tick();

    // Reset with buffered children and a pending finish.
    drive(1, 400, 1, 1, 0, 2, 0, 0); tick();
    drive(1, 400, 2, 2, 1, 2, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_pre_valid", 64'(bus.child_valid), 64'd1);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_child", 64'(bus.child_valid), 64'd0);
    chk("t5_rst_fin", 64'(bus.finish_valid), 64'd0);
    chk("t5_rst_idle", 64'(bus.idle), 64'd1);
    tick(); tick();
    rstn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    chk("t5_no_stale", 64'(bus.child_valid), 64'd0);

    // Child-count saturation.
    for (int i = 0; i < 260; i++) begin
      drive(1, 500, 32'(i), 32'(i), 0, 1, 1, 0);
      tick();
    end
    drive(1, 500, 1, 1, 1, 1, 1, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      if (bus.finish_valid) seen = 1'b1;
    end
    chk("t6_fin_seen", 64'(seen), 64'd1);
    chk("t6_fin_sat", 64'(bus.finish_n_children), 64'd255);
    chk("t6_overflow", 64'(bus.overflow), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    tick();

    // Randomized traffic; ts/slot held per parent.
    p_ts   = $urandom;
    p_slot = SLOT_W'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (parent_done) begin
        parent_done = 1'b0;
        p_ts   = $urandom;
        p_slot = SLOT_W'($urandom);
      end
      drive(bit'($urandom_range(0, 1)), p_ts, $urandom, $urandom,
            ($urandom_range(0, 3) == 0), p_slot,
            ($urandom_range(0, 2) != 0), bit'($urandom_range(0, 1)));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
